// File: rtl/rr_mux8_collector.sv
// rr_mux8_collector: fair round-robin collector for eight valid/ready
// producers. The granted channel's word goes into a single-entry output
// register that drains through a valid/ready handshake to one consumer.
module rr_mux8_collector #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [7:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_chan
);

  logic [2:0]       ptr;
  logic [2:0]       grant;
  logic             grant_valid;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] sel_data;
  logic [2:0]       idx;

  assign can_load = !out_valid || out_ready;

  // Search from ptr upward (wrapping) for the first requesting channel.
  always_comb begin
    grant       = 3'd0;
    grant_valid = 1'b0;
    idx         = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!grant_valid && in_valid[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

  // Only the granted channel sees ready, and only when the output register can take a word.
  always_comb begin
    in_ready = 8'h00;
    if (grant_valid && can_load && !reset)
      in_ready = 8'b1 << grant;
  end

  assign load = |(in_valid & in_ready);

  // Data path mux; its result only reaches the outputs through the register.
  always_comb begin
    sel_data = '0;
    case (grant)
      3'd0: sel_data = a;
      3'd1: sel_data = b;
      3'd2: sel_data = c;
      3'd3: sel_data = d;
      3'd4: sel_data = e;
      3'd5: sel_data = f;
      3'd6: sel_data = g;
      3'd7: sel_data = h;
      default: sel_data = '0;
    endcase
  end

  // Output register and round-robin pointer; a load wins over a drain so a
  // simultaneous in/out transfer keeps out_valid high for full throughput.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= 3'd0;
      ptr       <= 3'd0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= grant;
      ptr       <= grant + 3'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rr_mux8_collector.md
# rr_mux8_collector

Round-robin 8-channel, 16-bit word collector. It is the sequential stage built around the 8-way 16-bit selection path. It arbitrates among eight valid/ready input channels, selects the granted channel's word, and registers it into a single-entry output stage with a valid/ready handshake. It sits downstream of eight producers and feeds one consumer, replacing a fixed externally driven `sel` with fair, hazard-free selection.

## Interface
- `WIDTH`, 16, data word width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_valid` input 8: per-channel valid; bit i belongs to channel i.
- `a`, `b`, `c`, `d`, `e`, `f`, `g`, `h` input WIDTH each: channel 0..7 data words.
- `in_ready` output 8: per-channel ready; at most one bit high, and combinational.
- `out_valid` output 1: output register holds an untaken word.
- `out_ready` input 1: consumer accepts the word this cycle.
- `out_data` output WIDTH: registered selected word.
- `out_chan` output 3: registered index of the channel that supplied `out_data`.

## Operation
- Transfer rules:
  - An input transfer on channel i occurs on a rising edge where `in_valid[i]` and `in_ready[i]` are both high.
  - An output transfer occurs where `out_valid` and `out_ready` are both high.
- `can_load = !out_valid || out_ready`. The output register can accept a new word when it is empty or is being drained in the same cycle.
- Arbitration is combinational. `grant` is the first index `k` in the order `ptr`, `ptr+1`, ..., `ptr+7` (mod 8) with `in_valid[k]` high. If no channel is valid, there is no grant.
- `in_ready[grant] = can_load && !reset`. All other `in_ready` bits are 0. All bits are 0 when no channel is valid.
- On an input transfer from channel g:
  - `out_data` takes the g-th data input (0→`a` … 7→`h`).
  - `out_chan` takes g and `out_valid` takes 1.
  - `ptr` takes (g+1) mod 8, so 7 wraps to 0.
- On an output transfer with no simultaneous input transfer, `out_valid` takes 0. `out_data` and `out_chan` hold their last values.
- Simultaneous output and input transfer: the new word replaces the old one and `out_valid` stays 1. This gives full throughput of one word per cycle.
- While `out_valid=1` and `out_ready=0`:
  - `out_data`, `out_chan` and `out_valid` are stable.
  - All `in_ready` bits are 0.
  - `ptr` does not change.
- The input data value matters only on the transfer edge. Data on non-granted channels is ignored.
- Fairness: a channel that holds `in_valid` continuously is granted within 8 input transfers.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=0`, `in_ready=0`. These apply asynchronously on `reset` assertion.
- Reset mid-operation discards any held word; no output transfer is reported for it. The first edge after `reset` deasserts may accept a word.
- Latency: a word accepted at edge N appears on `out_data`/`out_chan` with `out_valid=1` immediately after edge N. This is one-cycle input-to-output latency.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `ptr`. There is no combinational path from the data inputs to any output.
- Producers must hold `in_valid` and data stable until their transfer. The block does not require this for correctness; it only samples data on the transfer edge.

## Test plan
- Reset, then `in_valid=8'h00` for 5 cycles:
  - Required: `out_valid=0`, `out_data=16'h0000`, `out_chan=0`, `in_ready=8'h00` throughout.
- Data `a..h` = `16'h1111`…`16'h8888`, `in_valid=8'hFF`, `out_ready=1` for 10 cycles from reset:
  - Required `out_chan` sequence: 0,1,2,3,4,5,6,7,0,1.
  - `out_data` matches each channel's word.
  - `out_valid` stays 1 after the first edge (one word per cycle).
- Backpressure: channel 2 holds `16'hF0F0` and is accepted; `out_ready=0` for 4 cycles while `in_valid=8'hFF`:
  - Required: `out_data=16'hF0F0`, `out_chan=2`, `in_ready=8'h00` throughout.
  - On the cycle `out_ready=1`, `in_ready=8'h08`, and the next word comes from channel 3.
- Wrap and skip: after a channel 6 transfer, `in_valid=8'b0000_0101`:
  - Required grant order: 0, then 2, then 0.
  - `ptr` wraps 7→0 correctly after a channel 7 transfer.
- Reset mid-operation: word `16'hCCCC` from channel 5 held with `out_ready=0`; assert `reset` between edges:
  - Required: `out_valid=0`, `out_data=0` and `in_ready=0` immediately.
  - After release, the first accepted channel is the lowest valid index from 0.
